// File: rtl/ft_bus_sched.sv
// ft_bus_sched: arbitrates the half-duplex FTDI FT245-style synchronous FIFO
// bus between RX bursts (FTDI -> FPGA) and TX bursts (FPGA -> FTDI).
//
// Parameters:
//   BURST_MAX  - max bytes moved per grant (1..255)
//   TURNAROUND - idle cycles after every burst before the next grant (1..3)
// Ports:
//   clk, rst                - 60 MHz FTDI clock, synchronous active-high reset
//   ftdi_rde_n, ftdi_txe_n  - FTDI FIFO status (low = byte ready / room)
//   rx_room, tx_valid       - local RX buffer space, local TX byte available
//   ftdi_oe_n/rd_n/wr_n     - FTDI bus controls (active low)
//   ftdi_drive              - FPGA drives the shared data bus
//   rx_strobe, tx_pop       - capture RX byte / consume TX byte this cycle
//   busy, burst_cnt         - scheduler not idle, bytes moved in this burst

module ft_bus_sched #(
    parameter int BURST_MAX  = 64,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ftdi_rde_n,
    input  logic       ftdi_txe_n,
    input  logic       rx_room,
    input  logic       tx_valid,
    output logic       ftdi_oe_n,
    output logic       ftdi_rd_n,
    output logic       ftdi_wr_n,
    output logic       ftdi_drive,
    output logic       rx_strobe,
    output logic       tx_pop,
    output logic       busy,
    output logic [7:0] burst_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_OE    = 3'd1,
        RX_READ  = 3'd2,
        TX_WRITE = 3'd3,
        TURN     = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX   = 8'(BURST_MAX);
    localparam logic [7:0] CNT_LAST  = 8'(BURST_MAX - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURNAROUND - 1);

    state_t     state;
    state_t     state_d;
    logic [7:0] cnt_d;
    logic       fair;
    logic       fair_d;
    logic [1:0] turn_cnt;
    logic [1:0] turn_d;
    logic       rx_req;
    logic       tx_req;
    logic [7:0] cnt_inc;

    assign rx_req  = ~ftdi_rde_n & rx_room;
    assign tx_req  = ~ftdi_txe_n & tx_valid;
    assign busy    = (state != IDLE);
    assign cnt_inc = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
            fair      <= 1'b0;
            turn_cnt  <= 2'd0;
        end else begin
            state     <= state_d;
            burst_cnt <= cnt_d;
            fair      <= fair_d;
            turn_cnt  <= turn_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = burst_cnt;
        fair_d     = fair;
        turn_d     = turn_cnt;
        ftdi_oe_n  = 1'b1;
        ftdi_rd_n  = 1'b1;
        ftdi_wr_n  = 1'b1;
        ftdi_drive = 1'b0;
        rx_strobe  = 1'b0;
        tx_pop     = 1'b0;

        case (state)
            IDLE: begin
                cnt_d  = 8'd0;
                turn_d = 2'd0;
                // A full RX burst hands the next grant to a waiting TX.
                if (tx_req && (fair || !rx_req)) begin
                    state_d = TX_WRITE;
                    fair_d  = 1'b0;
                end else if (rx_req) begin
                    state_d = RX_OE;
                    fair_d  = 1'b0;
                end
            end
            RX_OE: begin
                // FTDI needs OE one cycle before the first read.
                ftdi_oe_n = 1'b0;
                state_d   = RX_READ;
            end
            RX_READ: begin
                ftdi_oe_n = 1'b0;
                ftdi_rd_n = ~rx_req;
                rx_strobe = rx_req;
                if (!rx_req) begin
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_inc;
                    if (burst_cnt == CNT_LAST) begin
                        state_d = TURN;
                        fair_d  = 1'b1;
                    end
                end
            end
            TX_WRITE: begin
                ftdi_drive = 1'b1;
                ftdi_wr_n  = ~tx_req;
                tx_pop     = tx_req;
                if (!tx_req) begin
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_inc;
                    if (burst_cnt == CNT_LAST) begin
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    turn_d  = 2'd0;
                end else begin
                    turn_d = turn_cnt + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                turn_d  = 2'd0;
            end
        endcase

        // Keep the bus quiet while reset is held, whatever the state.
        if (rst) begin
            ftdi_oe_n  = 1'b1;
            ftdi_rd_n  = 1'b1;
            ftdi_wr_n  = 1'b1;
            ftdi_drive = 1'b0;
            rx_strobe  = 1'b0;
            tx_pop     = 1'b0;
        end
    end

endmodule

// File: doc/ft_bus_sched.md
FT_BUS_SCHED -- requirements
Module: ft_bus_sched

Interface
REQ-001 Parameter BURST_MAX, default 64, max bytes per grant (legal 1..255).
REQ-002 Parameter TURNAROUND, default 1, idle cycles between any burst end and the next grant (legal 1..3).
REQ-003 clk  in  1  single clock (FTDI 60 MHz domain); all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ftdi_rde_n  in  1  low = FTDI RX FIFO holds a byte.
REQ-006 ftdi_txe_n  in  1  low = FTDI TX FIFO can accept a byte.
REQ-007 rx_room  in  1  downstream RX buffer can accept a byte this cycle.
REQ-008 tx_valid  in  1  upstream TX byte available this cycle.
REQ-009 ftdi_oe_n  out  1  FTDI output enable, active low.
REQ-010 ftdi_rd_n  out  1  FTDI read strobe, active low.
REQ-011 ftdi_wr_n  out  1  FTDI write strobe, active low.
REQ-012 ftdi_drive  out  1  1 = FPGA drives the shared data bus.
REQ-013 rx_strobe  out  1  capture the bus byte this cycle.
REQ-014 tx_pop  out  1  current TX byte is consumed this cycle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 burst_cnt  out  8  bytes transferred in the current burst.

Function
REQ-017 States: IDLE, RX_OE, RX_READ, TX_WRITE, TURN; 3-bit encoding; any unused encoding SHALL return to IDLE on the next edge.
REQ-018 IDLE: oe_n=1, rd_n=1, wr_n=1, drive=0; burst_cnt cleared.
REQ-019 IDLE grant, rx_req = ~ftdi_rde_n & rx_room, tx_req = ~ftdi_txe_n & tx_valid; RX wins, except when the fair flag is set and tx_req is high, in which case TX wins.
REQ-020 Fair flag: set when an RX burst ends because burst_cnt reached BURST_MAX; cleared on any grant from IDLE.
REQ-021 RX grant -> RX_OE: oe_n=0, rd_n=1, drive=0; exactly one cycle; then RX_READ unconditionally.
REQ-022 RX_READ: oe_n=0; ftdi_rd_n = ~(~ftdi_rde_n & rx_room) (combinational); rx_strobe = ~ftdi_rd_n; burst_cnt += 1 on each strobe.
REQ-023 RX_READ exits to TURN on the next edge when ftdi_rde_n=1, or rx_room=0, or a strobe occurs with burst_cnt = BURST_MAX-1.
REQ-024 TX grant -> TX_WRITE: drive=1, oe_n=1; ftdi_wr_n = ~(~ftdi_txe_n & tx_valid) (combinational); tx_pop = ~ftdi_wr_n; burst_cnt += 1 on each pop.
REQ-025 TX_WRITE exits to TURN on the next edge when ftdi_txe_n=1, or tx_valid=0, or a pop occurs with burst_cnt = BURST_MAX-1.
REQ-026 TURN: oe_n=1, rd_n=1, wr_n=1, drive=0 for exactly TURNAROUND cycles, then IDLE; requests during TURN are ignored.
REQ-027 drive and oe_n SHALL never be simultaneously 1 and 0 respectively (no bus contention in any cycle).
REQ-028 rd_n and wr_n SHALL never both be low; rx_strobe and tx_pop SHALL never both be high.
REQ-029 burst_cnt saturates at BURST_MAX; it is 8 bits wide and never wraps.
REQ-030 Minimum gap IDLE-grant to first strobe: RX = 2 cycles (IDLE, RX_OE), TX = 1 cycle.

Reset
REQ-031 On an rst edge: state=IDLE, oe_n=1, rd_n=1, wr_n=1, drive=0, rx_strobe=0, tx_pop=0, busy=0, burst_cnt=0, fair flag=0, TURN counter=0.
REQ-032 Reset mid-burst SHALL abort the burst with no turnaround; combinational strobes SHALL be forced inactive while rst=1.

Verification
REQ-033 rde_n=0 steady, rx_room=1, 5 bytes then rde_n=1 -> oe_n low 1 cycle before rd_n; 5 rx_strobe pulses; burst_cnt=5; TURN 1 cycle; IDLE.
REQ-034 rde_n=0 continuous, tx_valid=1, txe_n=0, BURST_MAX=4 -> RX burst of 4, TURN, TX burst of 4 (fair flag), TURN, RX burst of 4.
REQ-035 TX burst, txe_n raised after 3 pops -> wr_n high in that same cycle, tx_pop count = 3, drive falls on entering TURN.
REQ-036 rde_n and txe_n both low, tx_valid=1, fair flag clear, in IDLE -> RX granted.
REQ-037 rst asserted in RX_READ at burst_cnt=2 -> next cycle all strobes high-inactive, oe_n=1, burst_cnt=0, state IDLE.
REQ-038 Random rde_n/txe_n/rx_room/tx_valid for 10,000 cycles -> REQ-027/028 assertions never fire; strobe count equals the sum of burst_cnt over all bursts.
